// File: rtl/reorder_buffer.sv
// Dual-issue reorder buffer: in-order allocation, out-of-order completion,
// and in-order retirement of up to two entries per cycle.
module reorder_buffer #(
  parameter  int DEPTH  = 16,
  parameter  int PREG_W = 6,
  parameter  int AREG_W = 5,
  localparam int TW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid_1,
  input  logic              alloc_valid_2,
  input  logic              alloc_wr_1,
  input  logic              alloc_wr_2,
  input  logic [AREG_W-1:0] alloc_rd_1,
  input  logic [AREG_W-1:0] alloc_rd_2,
  input  logic [PREG_W-1:0] alloc_newrd_1,
  input  logic [PREG_W-1:0] alloc_newrd_2,
  input  logic [PREG_W-1:0] alloc_oldrd_1,
  input  logic [PREG_W-1:0] alloc_oldrd_2,
  output logic              alloc_ready,
  output logic [TW-1:0]     alloc_tag_1,
  output logic [TW-1:0]     alloc_tag_2,
  input  logic              complete_valid_1,
  input  logic              complete_valid_2,
  input  logic [TW-1:0]     complete_tag_1,
  input  logic [TW-1:0]     complete_tag_2,
  input  logic              flush,
  output logic              retire_valid_1,
  output logic              retire_valid_2,
  output logic [AREG_W-1:0] retire_rd_1,
  output logic [AREG_W-1:0] retire_rd_2,
  output logic [PREG_W-1:0] retire_preg_1,
  output logic [PREG_W-1:0] retire_preg_2,
  output logic              free_valid_1,
  output logic              free_valid_2,
  output logic [PREG_W-1:0] free_preg_1,
  output logic [PREG_W-1:0] free_preg_2,
  output logic [TW:0]       count,
  output logic              full,
  output logic              empty
);

  logic [DEPTH-1:0]  ent_vld, ent_done, ent_wr;
  logic [AREG_W-1:0] ent_rd  [DEPTH];
  logic [PREG_W-1:0] ent_new [DEPTH];
  logic [PREG_W-1:0] ent_old [DEPTH];

  logic [TW-1:0] head, tail, head_n1, tail_n1;
  logic          acc_1, acc_2, ret_1, ret_2;
  logic [TW:0]   n_acc, n_ret;

  assign head_n1     = head + TW'(1);
  assign tail_n1     = tail + TW'(1);
  assign alloc_ready = (count <= (TW+1)'(DEPTH-2));
  assign acc_1       = alloc_ready & alloc_valid_1;
  assign acc_2       = alloc_ready & alloc_valid_2;
  assign alloc_tag_1 = tail;
  assign alloc_tag_2 = alloc_valid_1 ? tail_n1 : tail;
  assign n_acc       = (TW+1)'(acc_1) + (TW+1)'(acc_2);

  // Second slot may only retire when the head retires in the same cycle.
  assign ret_1 = ent_vld[head] & ent_done[head];
  assign ret_2 = ret_1 & ent_vld[head_n1] & ent_done[head_n1];
  assign n_ret = (TW+1)'(ret_1) + (TW+1)'(ret_2);

  assign full  = (count == (TW+1)'(DEPTH));
  assign empty = (count == '0);

  // Payload needs no reset: it is only observed through a valid entry.
  always_ff @(posedge clk) begin
    if (acc_1) begin
      ent_wr[tail]  <= alloc_wr_1;
      ent_rd[tail]  <= alloc_rd_1;
      ent_new[tail] <= alloc_newrd_1;
      ent_old[tail] <= alloc_oldrd_1;
    end
    if (acc_2) begin
      ent_wr[alloc_tag_2]  <= alloc_wr_2;
      ent_rd[alloc_tag_2]  <= alloc_rd_2;
      ent_new[alloc_tag_2] <= alloc_newrd_2;
      ent_old[alloc_tag_2] <= alloc_oldrd_2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      ent_vld        <= '0;
      ent_done       <= '0;
      retire_valid_1 <= 1'b0;
      retire_valid_2 <= 1'b0;
      free_valid_1   <= 1'b0;
      free_valid_2   <= 1'b0;
      retire_rd_1    <= '0;
      retire_rd_2    <= '0;
      retire_preg_1  <= '0;
      retire_preg_2  <= '0;
      free_preg_1    <= '0;
      free_preg_2    <= '0;
    end else if (flush) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      ent_vld        <= '0;
      ent_done       <= '0;
      retire_valid_1 <= 1'b0;
      retire_valid_2 <= 1'b0;
      free_valid_1   <= 1'b0;
      free_valid_2   <= 1'b0;
    end else begin
      // Alloc targets free slots and retire targets live ones, so they never collide.
      for (int i = 0; i < DEPTH; i++) begin
        if ((acc_1 && tail == TW'(i)) || (acc_2 && alloc_tag_2 == TW'(i))) begin
          ent_vld[i]  <= 1'b1;
          ent_done[i] <= 1'b0;
        end else if ((ret_1 && head == TW'(i)) || (ret_2 && head_n1 == TW'(i))) begin
          ent_vld[i]  <= 1'b0;
          ent_done[i] <= 1'b0;
        end else if (ent_vld[i] &&
                     ((complete_valid_1 && complete_tag_1 == TW'(i)) ||
                      (complete_valid_2 && complete_tag_2 == TW'(i)))) begin
          ent_done[i] <= 1'b1;
        end
      end
      retire_valid_1 <= ret_1;
      retire_valid_2 <= ret_2;
      free_valid_1   <= ret_1 & ent_wr[head];
      free_valid_2   <= ret_2 & ent_wr[head_n1];
      retire_rd_1    <= ent_rd[head];
      retire_rd_2    <= ent_rd[head_n1];
      retire_preg_1  <= ent_new[head];
      retire_preg_2  <= ent_new[head_n1];
      free_preg_1    <= ent_old[head];
      free_preg_2    <= ent_old[head_n1];
      head           <= head + TW'(n_ret);
      tail           <= tail + TW'(n_acc);
      count          <= count + n_acc - n_ret;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed vector table, hand-written corner
// sequences and random traffic checked against a queue-based model.
module tb_reorder_buffer;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_valid_1, alloc_valid_2, alloc_wr_1, alloc_wr_2;
  logic [4:0] alloc_rd_1, alloc_rd_2;
  logic [5:0] alloc_newrd_1, alloc_newrd_2, alloc_oldrd_1, alloc_oldrd_2;
  logic       alloc_ready;
  logic [3:0] alloc_tag_1, alloc_tag_2;
  logic       complete_valid_1, complete_valid_2;
  logic [3:0] complete_tag_1, complete_tag_2;
  logic       flush;
  logic       retire_valid_1, retire_valid_2;
  logic [4:0] retire_rd_1, retire_rd_2;
  logic [5:0] retire_preg_1, retire_preg_2;
  logic       free_valid_1, free_valid_2;
  logic [5:0] free_preg_1, free_preg_2;
  logic [4:0] count;
  logic       full, empty;

  reorder_buffer #(.DEPTH(DEPTH), .PREG_W(6), .AREG_W(5)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid_1(alloc_valid_1), .alloc_valid_2(alloc_valid_2),
    .alloc_wr_1(alloc_wr_1), .alloc_wr_2(alloc_wr_2),
    .alloc_rd_1(alloc_rd_1), .alloc_rd_2(alloc_rd_2),
    .alloc_newrd_1(alloc_newrd_1), .alloc_newrd_2(alloc_newrd_2),
    .alloc_oldrd_1(alloc_oldrd_1), .alloc_oldrd_2(alloc_oldrd_2),
    .alloc_ready(alloc_ready), .alloc_tag_1(alloc_tag_1), .alloc_tag_2(alloc_tag_2),
    .complete_valid_1(complete_valid_1), .complete_valid_2(complete_valid_2),
    .complete_tag_1(complete_tag_1), .complete_tag_2(complete_tag_2),
    .flush(flush),
    .retire_valid_1(retire_valid_1), .retire_valid_2(retire_valid_2),
    .retire_rd_1(retire_rd_1), .retire_rd_2(retire_rd_2),
    .retire_preg_1(retire_preg_1), .retire_preg_2(retire_preg_2),
    .free_valid_1(free_valid_1), .free_valid_2(free_valid_2),
    .free_preg_1(free_preg_1), .free_preg_2(free_preg_2),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct { int tag, wr, rd, nr, orr, done; } m_ent;
  typedef struct { int av1, av2, wr1, wr2, o1, o2, cv1, t1, cv2, t2,
                   cnt, rv1, rv2, fv1, fv2, fp1, fp2; } vec_t;

  m_ent mq[$];
  int   m_tail;
  int   e_rv1, e_rv2, e_fv1, e_fv2, e_rd1, e_rd2, e_pr1, e_pr2, e_fp1, e_fp2;
  int   n_chk = 0, n_err = 0;
  vec_t vt[21];

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr_exp();
    e_rv1 = 0; e_rv2 = 0; e_fv1 = 0; e_fv2 = 0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_tail = 0;
    clr_exp();
  endtask

  task automatic push(int wr, int rd, int nr, int orr);
    m_ent e;
    e.tag = m_tail; e.wr = wr; e.rd = rd; e.nr = nr; e.orr = orr; e.done = 0;
    mq.push_back(e);
    m_tail = (m_tail + 1) % DEPTH;
  endtask

  // One clock edge of the reference: retire from pre-edge done state,
  // then apply completions, then accept allocations.
  task automatic model_step();
    int   pre;
    m_ent e;
    pre = mq.size();
    clr_exp();
    if (flush) begin
      model_reset();
      return;
    end
    if (mq.size() > 0 && mq[0].done != 0) begin
      e = mq.pop_front();
      e_rv1 = 1; e_rd1 = e.rd; e_pr1 = e.nr; e_fv1 = e.wr; e_fp1 = e.orr;
      if (mq.size() > 0 && mq[0].done != 0) begin
        e = mq.pop_front();
        e_rv2 = 1; e_rd2 = e.rd; e_pr2 = e.nr; e_fv2 = e.wr; e_fp2 = e.orr;
      end
    end
    foreach (mq[i])
      if ((complete_valid_1 && mq[i].tag == int'(complete_tag_1)) ||
          (complete_valid_2 && mq[i].tag == int'(complete_tag_2)))
        mq[i].done = 1;
    if (pre <= DEPTH - 2) begin
      if (alloc_valid_1) push(int'(alloc_wr_1), int'(alloc_rd_1), int'(alloc_newrd_1), int'(alloc_oldrd_1));
      if (alloc_valid_2) push(int'(alloc_wr_2), int'(alloc_rd_2), int'(alloc_newrd_2), int'(alloc_oldrd_2));
    end
  endtask

  task automatic check_outputs();
    chk("alloc_ready", int'(alloc_ready), int'(mq.size() <= DEPTH - 2));
    chk("count", int'(count), mq.size());
    chk("full", int'(full), int'(mq.size() == DEPTH));
    chk("empty", int'(empty), int'(mq.size() == 0));
    chk("alloc_tag_1", int'(alloc_tag_1), m_tail);
    chk("alloc_tag_2", int'(alloc_tag_2), alloc_valid_1 ? (m_tail + 1) % DEPTH : m_tail);
    chk("retire_valid_1", int'(retire_valid_1), e_rv1);
    chk("retire_valid_2", int'(retire_valid_2), e_rv2);
    chk("free_valid_1", int'(free_valid_1), e_rv1 != 0 ? e_fv1 : 0);
    chk("free_valid_2", int'(free_valid_2), e_rv2 != 0 ? e_fv2 : 0);
    if (e_rv1 != 0) begin
      chk("retire_rd_1", int'(retire_rd_1), e_rd1);
      chk("retire_preg_1", int'(retire_preg_1), e_pr1);
      if (e_fv1 != 0) chk("free_preg_1", int'(free_preg_1), e_fp1);
    end
    if (e_rv2 != 0) begin
      chk("retire_rd_2", int'(retire_rd_2), e_rd2);
      chk("retire_preg_2", int'(retire_preg_2), e_pr2);
      if (e_fv2 != 0) chk("free_preg_2", int'(free_preg_2), e_fp2);
    end
  endtask

  task automatic drv(int av1, int av2, int wr1, int wr2, int o1, int o2,
                     int cv1, int t1, int cv2, int t2, int fl);
    alloc_valid_1 = av1[0];  alloc_valid_2 = av2[0];
    alloc_wr_1 = wr1[0];     alloc_wr_2 = wr2[0];
    alloc_oldrd_1 = 6'(o1);  alloc_oldrd_2 = 6'(o2);
    alloc_rd_1 = 5'(o1 + 3); alloc_rd_2 = 5'(o2 + 3);
    alloc_newrd_1 = 6'(o1 + 30); alloc_newrd_2 = 6'(o2 + 30);
    complete_valid_1 = cv1[0]; complete_tag_1 = 4'(t1);
    complete_valid_2 = cv2[0]; complete_tag_2 = 4'(t2);
    flush = fl[0];
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic do_cycle();
    #1 check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic fill_to_seven();
    drv(1, 1, 1, 1, 20, 21, 0, 0, 0, 0, 0); do_cycle();
    drv(1, 1, 1, 1, 22, 23, 0, 0, 0, 0, 0); do_cycle();
    drv(1, 1, 1, 1, 24, 25, 0, 0, 0, 0, 0); do_cycle();
    drv(1, 0, 1, 0, 26, 0, 1, 2, 1, 4, 0);  do_cycle();
    drv(0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0);   do_cycle();
    idle(); do_cycle();
    chk("seven_count", int'(count), 7);
    chk("seven_no_retire", int'(retire_valid_1), 0);
  endtask

  initial begin
    int seq;
    model_reset();
    idle();
    #12;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ready", int'(alloc_ready), 1);
    chk("rst_retire", int'(retire_valid_1 | retire_valid_2 | free_valid_1 | free_valid_2), 0);
    @(negedge clk);
    rst = 1'b0;

    vt[0]  = '{1,1,1,1,5,6,   0,0,0,0, 2, 0,0,0,0,0,0};
    vt[1]  = '{0,0,0,0,0,0,   1,0,1,1, 2, 0,0,0,0,0,0};
    vt[2]  = '{0,0,0,0,0,0,   0,0,0,0, 0, 1,1,1,1,5,6};
    vt[3]  = '{0,0,0,0,0,0,   0,0,0,0, 0, 0,0,0,0,0,0};
    vt[4]  = '{1,0,1,0,7,0,   0,0,0,0, 1, 0,0,0,0,0,0};
    vt[5]  = '{0,1,0,1,0,8,   0,0,0,0, 2, 0,0,0,0,0,0};
    vt[6]  = '{0,0,0,0,0,0,   1,3,0,0, 2, 0,0,0,0,0,0};
    vt[7]  = '{0,0,0,0,0,0,   0,0,0,0, 2, 0,0,0,0,0,0};
    vt[8]  = '{0,0,0,0,0,0,   0,0,1,2, 2, 0,0,0,0,0,0};
    vt[9]  = '{0,0,0,0,0,0,   0,0,0,0, 0, 1,1,1,1,7,8};
    vt[10] = '{1,0,0,0,9,0,   0,0,0,0, 1, 0,0,0,0,0,0};
    vt[11] = '{0,0,0,0,0,0,   1,4,0,0, 1, 0,0,0,0,0,0};
    vt[12] = '{0,0,0,0,0,0,   0,0,0,0, 0, 1,0,0,0,0,0};
    vt[13] = '{1,1,1,1,10,11, 0,0,0,0, 2, 0,0,0,0,0,0};
    vt[14] = '{0,0,0,0,0,0,   1,5,1,5, 2, 0,0,0,0,0,0};
    vt[15] = '{0,0,0,0,0,0,   1,6,0,0, 1, 1,0,1,0,10,0};
    vt[16] = '{0,0,0,0,0,0,   0,0,0,0, 0, 1,0,1,0,11,0};
    vt[17] = '{1,0,1,0,12,0,  1,9,0,0, 1, 0,0,0,0,0,0};
    vt[18] = '{0,0,0,0,0,0,   0,0,0,0, 1, 0,0,0,0,0,0};
    vt[19] = '{0,0,0,0,0,0,   1,7,0,0, 1, 0,0,0,0,0,0};
    vt[20] = '{0,0,0,0,0,0,   0,0,0,0, 0, 1,0,1,0,12,0};

    foreach (vt[i]) begin
      drv(vt[i].av1, vt[i].av2, vt[i].wr1, vt[i].wr2, vt[i].o1, vt[i].o2,
          vt[i].cv1, vt[i].t1, vt[i].cv2, vt[i].t2, 0);
      do_cycle();
      chk($sformatf("v%0d_count", i), int'(count), vt[i].cnt);
      chk($sformatf("v%0d_rv1", i), int'(retire_valid_1), vt[i].rv1);
      chk($sformatf("v%0d_rv2", i), int'(retire_valid_2), vt[i].rv2);
      chk($sformatf("v%0d_fv1", i), int'(free_valid_1), vt[i].fv1);
      chk($sformatf("v%0d_fv2", i), int'(free_valid_2), vt[i].fv2);
      if (vt[i].fv1 != 0) chk($sformatf("v%0d_fp1", i), int'(free_preg_1), vt[i].fp1);
      if (vt[i].fv2 != 0) chk($sformatf("v%0d_fp2", i), int'(free_preg_2), vt[i].fp2);
    end

    // Fill to 15: no longer ready, and a further request is dropped.
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); do_cycle();
    for (int k = 0; k < 7; k++) begin
      drv(1, 1, 1, 1, 2 * k, 2 * k + 1, 0, 0, 0, 0, 0); do_cycle();
    end
    drv(1, 0, 1, 0, 40, 0, 0, 0, 0, 0, 0); do_cycle();
    chk("fill15_count", int'(count), 15);
    chk("fill15_ready", int'(alloc_ready), 0);
    drv(1, 1, 1, 1, 41, 42, 0, 0, 0, 0, 0); do_cycle();
    chk("fill15_dropped", int'(count), 15);

    // Fill to 16 via a double alloc from 14.
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); do_cycle();
    for (int k = 0; k < 8; k++) begin
      drv(1, 1, 1, 1, 2 * k, 2 * k + 1, 0, 0, 0, 0, 0); do_cycle();
    end
    idle();
    chk("fill16_count", int'(count), 16);
    chk("fill16_full", int'(full), 1);
    chk("fill16_ready", int'(alloc_ready), 0);

    // Flush with 7 entries, 3 of them done behind an undone head.
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); do_cycle();
    fill_to_seven();
    drv(1, 1, 1, 1, 50, 51, 1, 0, 1, 1, 1); do_cycle();
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_retire", int'(retire_valid_1 | retire_valid_2 | free_valid_1 | free_valid_2), 0);
    idle(); do_cycle();
    chk("flush_next_retire", int'(retire_valid_1 | retire_valid_2 | free_valid_1 | free_valid_2), 0);

    // Asynchronous reset mid-stream.
    fill_to_seven();
    rst = 1'b1;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_ready", int'(alloc_ready), 1);
    model_reset();
    @(posedge clk);
    #1 chk("arst_retire", int'(retire_valid_1 | retire_valid_2 | free_valid_1 | free_valid_2), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(); do_cycle();
    drv(1, 1, 1, 0, 60, 61, 0, 0, 0, 0, 0); do_cycle();
    drv(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0); do_cycle();
    idle(); do_cycle();
    chk("arst_resume_rv2", int'(retire_valid_2), 1);

    // Random traffic; tags wrap many times, model checks order and counts.
    seq = 0;
    for (int c = 0; c < 800; c++) begin
      int t1, t2;
      t1 = (mq.size() > 0 && $urandom_range(0, 99) < 80) ? mq[$urandom_range(0, mq.size() - 1)].tag
                                                         : int'($urandom_range(0, DEPTH - 1));
      t2 = (mq.size() > 0 && $urandom_range(0, 99) < 80) ? mq[$urandom_range(0, mq.size() - 1)].tag
                                                         : int'($urandom_range(0, DEPTH - 1));
      drv(int'($urandom_range(0, 99) < 60), int'($urandom_range(0, 99) < 50),
          int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
          int'($urandom_range(0, 99) < 60), t1, int'($urandom_range(0, 99) < 50), t2,
          int'($urandom_range(0, 199) == 0));
      alloc_newrd_1 = 6'(seq);
      alloc_newrd_2 = 6'(seq + 1);
      seq += 2;
      do_cycle();
    end
    idle(); do_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
